i2c_master_ctrl: RTL

Single-master I2C transaction controller that sequences one complete single-byte bus transaction per command: START, 7-bit address plus R/W, ACK check, one data byte, ACK/NACK, and STOP. It sits between the system-clock register/bus side and the on-board I2C pins. It generates SCL from the system clock and drives SDA open-drain, so the LED peripheral slave and any other 7-bit-address slaves on the bus can be written or read.

---
 rtl/i2c_master_ctrl_if.sv | 23 ++
 rtl/i2c_master_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl_if.sv
// Command/status bundle between the system-side requester and the I2C master controller.
// The requester holds the master modport; the controller holds the slave modport.
interface i2c_master_ctrl_if;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [3:0] mst_state;

    modport master (
        output start, addr, rw, wdata,
        input  rdata, busy, done, ack_err, mst_state
    );

    modport slave (
        input  start, addr, rw, wdata,
        output rdata, busy, done, ack_err, mst_state
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: one START / address+R/W / ACK / data byte / ACK-NACK / STOP per command.
// SCL is push-pull from a quarter-period tick; SDA is open-drain (drive 0 or release).
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic             clk,
    input  logic             reset_n,
    i2c_master_ctrl_if.slave bus,
    output logic             i2c_scl,
    inout  wire              i2c_sda
);
    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        ADDR     = 4'd2,
        ADDR_ACK = 4'd3,
        WRITE    = 4'd4,
        WACK     = 4'd5,
        READ     = 4'd6,
        RNACK    = 4'd7,
        STOP     = 4'd8
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_qCnt;
    logic [1:0]       r_phase;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_txShift;
    logic [7:0]       r_rxShift;
    logic [7:0]       r_wdata;
    logic [7:0]       r_rdata;
    logic             r_rw;
    logic             r_sampled;
    logic             r_sdaOe;
    logic             r_done;
    logic             r_ackErr;
    logic             w_tick;
    logic             w_cellEnd;
    logic             w_accept;
    logic             w_lastBit;
    logic             w_sdaIn;

    assign w_sdaIn   = i2c_sda;
    assign w_tick    = (r_state != IDLE) && (r_qCnt == CNT_W'(CLK_DIV - 1));
    assign w_cellEnd = w_tick && (r_phase == 2'd3);
    assign w_accept  = (r_state == IDLE) && bus.start;
    assign w_lastBit = (r_bitCnt == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (bus.start)              w_nextState = START;
            START:    if (w_cellEnd)              w_nextState = ADDR;
            ADDR:     if (w_cellEnd && w_lastBit) w_nextState = ADDR_ACK;
            ADDR_ACK: if (w_cellEnd)              w_nextState = r_sampled ? STOP : (r_rw ? READ : WRITE);
            WRITE:    if (w_cellEnd && w_lastBit) w_nextState = WACK;
            WACK:     if (w_cellEnd)              w_nextState = STOP;
            READ:     if (w_cellEnd && w_lastBit) w_nextState = RNACK;
            RNACK:    if (w_cellEnd)              w_nextState = STOP;
            STOP:     if (w_cellEnd)              w_nextState = IDLE;
            default:                              w_nextState = IDLE;
        endcase
    end

    // SDA moves on P1 entry, is sampled on P3 entry; STOP drives low from P0 and releases on P3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_qCnt    <= '0;
            r_phase   <= 2'd0;
            r_bitCnt  <= 3'd0;
            r_txShift <= 8'h00;
            r_rxShift <= 8'h00;
            r_wdata   <= 8'h00;
            r_rdata   <= 8'h00;
            r_rw      <= 1'b0;
            r_sampled <= 1'b1;
            r_sdaOe   <= 1'b0;
            r_done    <= 1'b0;
            r_ackErr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                r_qCnt  <= '0;
                r_phase <= 2'd0;
            end else if (w_tick) begin
                r_qCnt  <= '0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_qCnt <= r_qCnt + 1'b1;
            end

            if (w_accept) begin
                r_rw      <= bus.rw;
                r_wdata   <= bus.wdata;
                r_txShift <= {bus.addr, bus.rw};
                r_ackErr  <= 1'b0;
            end

            if (w_tick && r_phase == 2'd0) begin
                case (r_state)
                    ADDR, WRITE:                r_sdaOe <= ~r_txShift[7];
                    ADDR_ACK, WACK, READ, RNACK: r_sdaOe <= 1'b0;
                    default:                    ;
                endcase
            end
            if (w_tick && r_phase == 2'd1 && r_state == START) begin
                r_sdaOe <= 1'b1;
            end
            if (w_tick && r_phase == 2'd2) begin
                r_sampled <= w_sdaIn;
                if (r_state == READ) begin
                    r_rxShift <= {r_rxShift[6:0], w_sdaIn};
                end
                if (r_state == STOP) begin
                    r_sdaOe <= 1'b0;
                end
            end

            if (w_cellEnd) begin
                r_bitCnt <= (w_nextState != r_state) ? 3'd0 : r_bitCnt + 3'd1;
                if (r_state == ADDR || r_state == WRITE) begin
                    r_txShift <= {r_txShift[6:0], 1'b0};
                end
                if (r_state == ADDR_ACK && w_nextState == WRITE) begin
                    r_txShift <= r_wdata;
                end
                if ((r_state == ADDR_ACK || r_state == WACK) && r_sampled) begin
                    r_ackErr <= 1'b1;
                end
                if (r_state == READ && w_nextState == RNACK) begin
                    r_rdata <= r_rxShift;
                end
                if (w_nextState == STOP && r_state != STOP) begin
                    r_sdaOe <= 1'b1;
                end
                if (r_state == STOP) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // SCL stays high through IDLE and the START cell so the START condition is a clean SDA fall.
    assign i2c_sda       = r_sdaOe ? 1'b0 : 1'bz;
    assign i2c_scl       = (r_state == IDLE || r_state == START) ? 1'b1 : r_phase[1];
    assign bus.rdata     = r_rdata;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.ack_err   = r_ackErr;
    assign bus.mst_state = r_state;
endmodule
